load_use_stall_ctrl: RTL
========================

// Module: load_use_stall_ctrl
// PURPOSE
//   Consumer side of the load-tracking pipeline buffers. The EX-stage load flag and destination,
//   and the ID-stage source registers, drive the detection of load-use hazards.
//   On a hit it freezes PC and IF/ID and inserts bubbles into ID/EX for a fixed number of cycles.
//   This covers the span until the load reaches the forwarding point after the MEM2 stage.
//   It sits beside the hazard/forwarding logic and drives the PC, IF/ID and ID/EX enables.
// PARAMETERS
//   STALL_CYCLES  2  bubbles per load-use hit (load EX->MEM1->MEM2 span); legal range 1..7
//   CNT_W         3  counter width; must hold STALL_CYCLES
// PORTS
//   i_clk          in   1      clock, rising edge
//   i_rst_n        in   1      asynchronous reset, active low
//   i_EX_Memread   in   1      instruction in EX is a load
//   i_EX_rd        in   5      destination of instruction in EX
//   i_ID_rs1       in   5      rs1 of instruction in ID
//   i_ID_rs2       in   5      rs2 of instruction in ID
//   i_ID_use_rs1   in   1      ID instruction reads rs1
//   i_ID_use_rs2   in   1      ID instruction reads rs2
//   i_mem_stall    in   1      global freeze (data-memory busy); whole pipe holds
//   i_flush        in   1      branch/jump redirect; squashes IF and ID
//   o_pc_hold      out  1      1 = PC keeps its value
//   o_ifid_hold    out  1      1 = IF/ID register keeps its value
//   o_idex_bubble  out  1      1 = ID/EX loads a NOP (Memread=0, RegWrite=0, rd=0)
//   o_stall_cnt    out  CNT_W  remaining bubbles including the current cycle; 0 in IDLE
// BEHAVIOUR
//   Reset (i_rst_n=0, async): state IDLE, cnt=0, all outputs 0; reset mid-stall aborts it at once.
//   hit = i_EX_Memread & (i_EX_rd!=0) &
//         ((i_ID_use_rs1 & i_ID_rs1==i_EX_rd) | (i_ID_use_rs2 & i_ID_rs2==i_EX_rd)).
//   Register x0 never hits.
//   FSM, 2 states:
//    IDLE:  hit & !i_flush & !i_mem_stall -> outputs assert combinationally this cycle.
//           cnt <= STALL_CYCLES-1; go STALL if STALL_CYCLES>1, else stay IDLE.
//           The one-cycle case is bubble only in the hit cycle.
//    STALL: hold/bubble outputs 1 while cnt!=0. Each unfrozen edge does cnt <= cnt-1.
//           Leave to IDLE on the edge where cnt goes 1->0.
//           Hit detection is ignored in STALL.
//           After the bubble the original load has left EX, so no re-trigger is possible.
//   o_stall_cnt: IDLE&hit -> STALL_CYCLES; STALL -> cnt; otherwise 0.
//   Latency: zero-cycle assert in the hit cycle; exactly STALL_CYCLES consecutive unfrozen bubble cycles.
//   i_mem_stall=1: state and cnt frozen; outputs keep their last values.
//     o_idex_bubble is forced 0, because the whole pipe holds and no bubble is injected.
//     Hit detection is suppressed while frozen.
//     A hit seen with i_mem_stall=1 is detected on the first unfrozen cycle, since inputs are held.
//   i_flush=1: the ID instruction is dead.
//     Go IDLE, cnt=0, all outputs 0 that cycle; flush beats hit and i_mem_stall.
//   Back-to-back: a hit on the cycle after returning to IDLE starts a new full stall.
//     No merging with the previous stall.
//   All outputs are derived from state/cnt plus a single-level compare. No latches; no X on outputs after reset.
// TESTING
//   lw x5 in EX, ID add x6,x5,x1 (use_rs1) -> pc_hold/ifid_hold/idex_bubble=1 for exactly 2 cycles.
//     stall_cnt reads 2,1, then 0 with outputs low.
//   EX_rd=0 with Memread=1 and rs1=0 used -> no stall. Load in EX to x5, ID reads x5 with use flags=0 -> no stall.
//   Hit at cycle 0, i_mem_stall=1 during cycles 1-3 -> bubbles only in unfrozen cycles (0 and 4).
//     cnt holds 1 while frozen.
//   Hit, then i_flush=1 in the second stall cycle -> outputs drop that cycle, state IDLE, cnt=0.
//     Flush coincident with hit -> no stall.
//   i_rst_n pulsed low mid-stall (async, between edges) -> outputs 0 immediately.
//     After release, no stall until a new hit.
//   STALL_CYCLES=1 and 4 builds: bubble count per hit equals the parameter.
//     Back-to-back dependent loads give 2x the parameter.

Source files
------------

// File: rtl/load_use_stall_ctrl.sv
// Load-use hazard stall controller: freezes PC and IF/ID and injects ID/EX bubbles
// for STALL_CYCLES cycles after a load in EX feeds a source of the ID instruction.
module load_use_stall_ctrl #(
    parameter int unsigned STALL_CYCLES = 2,
    parameter int unsigned CNT_W        = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_EX_Memread,
    input  logic [4:0]       i_EX_rd,
    input  logic [4:0]       i_ID_rs1,
    input  logic [4:0]       i_ID_rs2,
    input  logic             i_ID_use_rs1,
    input  logic             i_ID_use_rs2,
    input  logic             i_mem_stall,
    input  logic             i_flush,
    output logic             o_pc_hold,
    output logic             o_ifid_hold,
    output logic             o_idex_bubble,
    output logic [CNT_W-1:0] o_stall_cnt
);

    typedef enum logic {
        IDLE,
        STALL
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             hit;
    logic             rs1_match;
    logic             rs2_match;

    assign rs1_match = i_ID_use_rs1 && (i_ID_rs1 == i_EX_rd);
    assign rs2_match = i_ID_use_rs2 && (i_ID_rs2 == i_EX_rd);
    assign hit       = i_EX_Memread && (i_EX_rd != 5'd0) && (rs1_match || rs2_match);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // cnt already holds STALL_CYCLES-1 on entry to STALL: the hit cycle is the first bubble
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (i_flush) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (!i_mem_stall) begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        cnt_nxt   = CNT_W'(STALL_CYCLES - 1);
                        state_nxt = (STALL_CYCLES > 1) ? STALL : IDLE;
                    end
                end
                STALL: begin
                    cnt_nxt = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Reset gates the hit path too, so inputs held during reset cannot assert outputs
    always_comb begin
        o_pc_hold     = 1'b0;
        o_ifid_hold   = 1'b0;
        o_idex_bubble = 1'b0;
        o_stall_cnt   = '0;
        if (i_rst_n && !i_flush) begin
            case (state)
                IDLE: begin
                    if (hit && !i_mem_stall) begin
                        o_pc_hold     = 1'b1;
                        o_ifid_hold   = 1'b1;
                        o_idex_bubble = 1'b1;
                        o_stall_cnt   = CNT_W'(STALL_CYCLES);
                    end
                end
                STALL: begin
                    if (cnt != '0) begin
                        o_pc_hold     = 1'b1;
                        o_ifid_hold   = 1'b1;
                        o_idex_bubble = !i_mem_stall;
                        o_stall_cnt   = cnt;
                    end
                end
                default: begin
                    o_pc_hold = 1'b0;
                end
            endcase
        end
    end

    a_stall_cnt_nonzero: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (state == STALL) |-> (cnt != '0));
    a_idle_cnt_zero: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (state == IDLE) |-> (cnt == '0));
    a_cnt_bound: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        cnt <= CNT_W'(STALL_CYCLES));
    a_flush_quiet: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_flush |-> (!o_pc_hold && !o_ifid_hold && !o_idex_bubble && (o_stall_cnt == '0)));

endmodule
